// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit CLA segment per stage, registered outputs.
// Define ADDSUB_SAT_EN to saturate SUM on signed overflow (default build wraps).
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [1:0]       op_mode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             C_out,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative
);

    localparam int NST  = WIDTH / SEG;
    // Remaining conditioned-Y bits of every stage packed into one triangular vector.
    localparam int YTOT = NST * WIDTH - SEG * ((NST * (NST - 1)) / 2);

    logic             en;
    logic [WIDTH-1:0] acc_s [0:NST];
    logic             c_s   [0:NST];
    logic             v_s   [0:NST];
    logic [YTOT-1:0]  y_s;
    logic             cmsb_s;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign acc_s[0]        = X;
    assign y_s[WIDTH-1:0]  = Y ^ {WIDTH{op_mode[0]}};
    assign c_s[0]          = op_mode[1] ? (cin ^ op_mode[0]) : op_mode[0];
    assign v_s[0]          = in_valid;

    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           ci);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < SEG; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    for (genvar k = 0; k < NST; k++) begin : g_st
        localparam int LO = k * SEG;
        localparam int YO = k * WIDTH - SEG * ((k * (k - 1)) / 2);
        localparam int YW = WIDTH - LO;

        logic [SEG-1:0]   seg_a;
        logic [SEG-1:0]   seg_b;
        logic [SEG-1:0]   seg_sum;
        logic             seg_co;
        logic [WIDTH-1:0] acc_nx;
        logic [WIDTH-1:0] acc_q;
        logic             c_q;
        logic             v_q;

        assign seg_a = acc_s[k][LO +: SEG];
        assign seg_b = y_s[YO +: SEG];
        assign {seg_co, seg_sum} = cla_seg(seg_a, seg_b, c_s[k]);

        // Low bits carry finished sum, high bits still hold unprocessed X.
        always_comb begin
            acc_nx             = acc_s[k];
            acc_nx[LO +: SEG]  = seg_sum;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                acc_q <= '0;
            end else if (en) begin
                v_q   <= v_s[k];
                c_q   <= seg_co;
                acc_q <= acc_nx;
            end
        end

        assign acc_s[k+1] = acc_q;
        assign c_s[k+1]   = c_q;
        assign v_s[k+1]   = v_q;

        if (k < NST - 1) begin : g_yrem
            logic [YW-SEG-1:0] yrem_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    yrem_q <= '0;
                end else if (en) begin
                    yrem_q <= y_s[YO+SEG +: YW-SEG];
                end
            end
            assign y_s[YO+YW +: YW-SEG] = yrem_q;
        end else begin : g_msb
            logic cmsb_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cmsb_q <= 1'b0;
                end else if (en) begin
                    cmsb_q <= seg_a[SEG-1] ^ seg_b[SEG-1] ^ seg_sum[SEG-1];
                end
            end
            assign cmsb_s = cmsb_q;
        end
    end

    logic             ovf;
    logic [WIDTH-1:0] res;

    assign ovf = cmsb_s ^ c_s[NST];

    always_comb begin
        res = acc_s[NST];
`ifdef ADDSUB_SAT_EN
        // Wrapped MSB is the inverse of the true sign on overflow.
        if (ovf) begin
            res = acc_s[NST][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                      : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            SUM       <= '0;
            C_out     <= 1'b0;
            Overflow  <= 1'b0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
        end else if (en) begin
            out_valid <= v_s[NST];
            if (v_s[NST]) begin
                SUM      <= res;
                C_out    <= c_s[NST];
                Overflow <= ovf;
                Zero     <= (res == '0);
                Negative <= res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed corner cases, stall, bubbles, reset and random traffic.
module tb_pipelined_addsub;

    localparam int W   = 16;
    localparam int S   = 4;
    localparam int NST = W / S;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic [1:0]   op_mode;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] SUM;
    logic         C_out;
    logic         Overflow;
    logic         Zero;
    logic         Negative;

    pipelined_addsub #(.WIDTH(W), .SEG(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .op_mode(op_mode), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .SUM(SUM), .C_out(C_out), .Overflow(Overflow), .Zero(Zero), .Negative(Negative)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        logic         z;
        logic         n;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: integer arithmetic on the signed and unsigned interpretations.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [1:0] op, input logic ci);
        exp_t r;
        int   sx = $signed(x);
        int   sy = $signed(y);
        int   ux = int'(x);
        int   uy = int'(y);
        int   cb = op[1] ? int'(ci) : 0;
        int   ts;
        int   tu;
        if (!op[0]) begin
            ts   = sx + sy + cb;
            tu   = ux + uy + cb;
            r.co = (tu >= 65536);
        end else begin
            ts   = sx - sy - cb;
            tu   = ux - uy - cb;
            r.co = (tu >= 0);
        end
        r.ov  = (ts > 32767) || (ts < -32768);
        r.sum = tu[W-1:0];
`ifdef ADDSUB_SAT_EN
        if (r.ov) r.sum = (ts > 0) ? 16'h7FFF : 16'h8000;
`endif
        r.z = (r.sum == 16'h0000);
        r.n = r.sum[W-1];
        return r;
    endfunction

    task automatic push_cur();
        sb.push_back(model(X, Y, op_mode, cin));
    endtask

    // Monitor: consume one expected entry per handshake.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'({SUM, C_out, Overflow, Zero, Negative}), 32'(e));
            end
        end
    end

    task automatic drain(input string name);
        int g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic single(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [1:0] op, input logic ci, input logic [W-1:0] es,
                          input logic eco, input logic eov, input logic ez, input logic en_);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        X = x; Y = y; op_mode = op; cin = ci; in_valid = 1'b1;
        #1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        if (in_ready) push_cur();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk({name, "_latency"}, lat, NST);
        chk(name, 32'({SUM, C_out, Overflow, Zero, Negative}), 32'({es, eco, eov, ez, en_}));
    endtask

    initial begin
        logic [2:0]  pat;
        logic [31:0] snap;
        int          i;
        int          cyc;
        logic        pend;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        X = '0; Y = '0; op_mode = 2'b00; cin = 1'b0;
        #12;
        chk("reset_state", 32'({out_valid, SUM, C_out, Overflow, Zero, Negative}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef ADDSUB_SAT_EN
        single("add_ovf", 16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        single("sub_ovf", 16'h8000, 16'h0001, 2'b01, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
`else
        single("add_ovf", 16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        single("sub_ovf", 16'h8000, 16'h0001, 2'b01, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
        single("sub_neg",  16'h0000, 16'h0001, 2'b01, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        single("sub_zero", 16'h1234, 16'h1234, 2'b01, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        single("xseg",     16'h0FFF, 16'h0001, 2'b00, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        single("adc",      16'h00FF, 16'h0001, 2'b10, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0);
        single("sbb",      16'h0005, 16'h0002, 2'b11, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        single("wrap",     16'hFFFF, 16'h0001, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        drain("drain_directed");

        // Stream with a 3-cycle output stall.
        i = 1; cyc = 0; snap = '0;
        while (i <= 8 && cyc < 100) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc < 9);
            X = 16'(i); Y = 16'(2 * i); op_mode = 2'b00; cin = 1'b0; in_valid = 1'b1;
            #1;
            if (!out_ready) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                if (cyc > 6) chk("stall_hold", 32'({out_valid, SUM, C_out, Overflow, Zero, Negative}), snap);
                snap = 32'({out_valid, SUM, C_out, Overflow, Zero, Negative});
            end
            if (in_valid && in_ready) begin
                push_cur();
                i++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        drain("drain_stream");

        // Bubble pattern 1,0,1 reappears NST+1 negedges later.
        pat = 3'b101;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            out_ready = 1'b1;
            X = 16'(t + 100); Y = 16'(t); op_mode = 2'b01; cin = 1'b0;
            in_valid = (t < 3) ? pat[2 - t] : 1'b0;
            #1;
            if (in_valid && in_ready) push_cur();
            if (t >= 5) chk("bubble_pattern", 32'(out_valid), 32'(pat[7 - t]));
        end
        drain("drain_bubble");

        // Asynchronous reset with three operations in flight.
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            X = 16'(t * 7 + 1); Y = 16'(t + 3); op_mode = 2'b00; cin = 1'b0; in_valid = 1'b1;
            #1;
            if (in_ready) push_cur();
        end
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_reset", 32'({out_valid, SUM, C_out, Overflow, Zero, Negative}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            #1;
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        single("post_reset", 16'h4321, 16'h1111, 2'b01, 1'b0, 16'h3210, 1'b1, 1'b0, 1'b0, 1'b0);
        drain("drain_reset");

        // Random traffic with random backpressure.
        pend = 1'b0;
        repeat (600) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 4) != 0);
            if (!pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    X = 16'($urandom); Y = 16'($urandom);
                    op_mode = 2'($urandom_range(0, 3)); cin = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                    pend = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            if (in_valid && in_ready) begin
                push_cur();
                pend = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the 8-bit combinational CLA add/sub.
- Splits the WIDTH-bit carry chain into SEG-bit CLA segments, one segment per pipeline stage, with the carry registered between stages.
- Adds carry-in modes, valid/ready flow control with backpressure, and zero/negative flags.
- Sits between the operand-issue logic and the result/writeback path of the datapath.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage (CLA group width); number of stages NST = WIDTH/SEG.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block can accept an operation this cycle.
- X  input  WIDTH  operand A.
- Y  input  WIDTH  operand B.
- op_mode  input  2  00 add; 01 sub; 10 add with carry; 11 sub with borrow.
- cin  input  1  carry/borrow-in; used only for op_mode 1x.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- SUM  output  WIDTH  result.
- C_out  output  1  carry out of the MSB; for subtraction 1 means no borrow.
- Overflow  output  1  signed overflow.
- Zero  output  1  SUM == 0.
- Negative  output  1  SUM[WIDTH-1].

Behaviour:
- Reset (asynchronous, while rst_n = 0): all stage valid bits clear; out_valid = 0; SUM, C_out, Overflow, Zero and Negative = 0.
  - Reset mid-operation discards every in-flight operation.
  - Nothing is emitted after release until new operations are accepted.
- Operand conditioning at stage 0: Y' = Y XOR {WIDTH{op_mode[0]}}. Initial carry c0 per op_mode:
  - 00: c0 = 0.
  - 01: c0 = 1.
  - 10: c0 = cin.
  - 11: c0 = NOT cin (cin = 1 means borrow).
- Pipeline, stage k (0..NST-1):
  - Adds X[k*SEG +: SEG] + Y'[k*SEG +: SEG] + carry_k with SEG-bit carry lookahead.
  - Registers the segment sum, carry_k+1, a valid bit, and the not-yet-processed upper operand bits.
  - Lower sum bits already computed are forwarded (skewed) so all bits of one operation reach the output together.
- Latency: exactly NST cycles from the accepting edge to out_valid = 1 when there is no stall (WIDTH = 16, SEG = 4: 4 cycles).
- Throughput: one operation per cycle.
- Flags:
  - C_out = carry out of bit WIDTH-1.
  - Overflow = carry into MSB XOR carry out of MSB.
  - Zero and Negative are computed on the final SUM, after saturation if enabled.
- Handshake:
  - Global advance en = !out_valid || out_ready; in_ready = en.
  - An operation is accepted on an edge where in_valid && in_ready.
  - When en = 0, every stage register holds, and SUM, flags and out_valid stay stable until out_ready.
  - A result is consumed on out_valid && out_ready; a new result may appear on the same edge (no bubble).
  - in_valid = 0 with en = 1 inserts a bubble; the stage valid bit is 0.
- Ordering: results leave strictly in acceptance order; no loss, no duplication.
- Outputs are registered; no combinational path from X/Y to SUM.
- Invalid stages may hold arbitrary data, but the output registers update only when a valid operation reaches them.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: on signed overflow, SUM saturates to 0x7F..F if the true result is positive, or 0x80..0 if negative. Overflow and C_out still report the unsaturated condition. Zero and Negative are computed on the saturated SUM. Latency unchanged.
- Undefined: SUM wraps modulo 2^WIDTH.

Test Plan (WIDTH = 16, SEG = 4):
- Add 0x7FFF + 0x0001, op 00 → after 4 cycles SUM = 0x8000, C_out = 0, Overflow = 1, Negative = 1; with ADDSUB_SAT_EN, SUM = 0x7FFF, Negative = 0.
- Sub 0x0000 − 0x0001, op 01 → SUM = 0xFFFF, C_out = 0, Overflow = 0, Negative = 1. Sub 0x1234 − 0x1234 → SUM = 0x0000, C_out = 1, Zero = 1.
- Cross-segment carry: 0x0FFF + 0x0001 → 0x1000. Op 10 with cin = 1: 0x00FF + 0x0001 → 0x0101. Op 11 with cin = 1: 0x0005 − 0x0002 → 0x0002, C_out = 1.
- Stream 8 back-to-back ops (operands i and 2i, i = 1..8), out_ready held low for 3 cycles mid-stream → in_ready low during stall, outputs stable, all 8 results 3i in order, none lost or duplicated.
- Bubbles: in_valid toggling 1, 0, 1 → out_valid pattern 1, 0, 1 offset by 4 cycles.
- Assert rst_n low for 1 cycle with 3 ops in flight → out_valid and all outputs 0 immediately (asynchronous); no stale result after release; a new op returns its correct result 4 cycles after acceptance.
